// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared word width and sequencer state encoding
package fetch_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control, program-counter, memory and consumer signals of the fetch sequencer
//
// slave  : sequencer side (control/memory/consumer inputs, pc/mem/instr/status outputs)
// master : environment side (drives run/halt/jump/stall/ack/pc_value/memory response)
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic  run;
    logic  halt_req;
    logic  jump_valid;
    word_t jump_addr;
    logic  stall;
    logic  instr_ack;
    word_t pc_value;
    logic  pc_enable;
    logic  pc_load;
    word_t pc_load_val;
    logic  mem_req;
    word_t mem_addr;
    logic  mem_ready;
    word_t mem_rdata;
    logic  instr_valid;
    word_t instr_out;
    logic  busy;
    logic  error;

    modport slave (
        input  run, halt_req, jump_valid, jump_addr, stall, instr_ack,
        input  pc_value, mem_ready, mem_rdata,
        output pc_enable, pc_load, pc_load_val, mem_req, mem_addr,
        output instr_valid, instr_out, busy, error
    );

    modport master (
        output run, halt_req, jump_valid, jump_addr, stall, instr_ack,
        output pc_value, mem_ready, mem_rdata,
        input  pc_enable, pc_load, pc_load_val, mem_req, mem_addr,
        input  instr_valid, instr_out, busy, error
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - counts unanswered memory request cycles and flags the timeout
//
// clk, reset : clock, asynchronous active-high reset
// clear      : return count to zero (wins over count_en)
// count_en   : one more cycle waited for memory
// expire     : this counted cycle is the MEM_TIMEOUT-th consecutive wait
module fetch_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    // Fires while the count still reads MEM_TIMEOUT-1 so the sequencer can
    // leave REQ on the same edge that the count reaches MEM_TIMEOUT.
    assign expire = count_en && !clear && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer driving an external PC and instruction memory
//
// clk   : clock, rising edge
// reset : asynchronous active-high reset
// bus   : fetch_sequencer_if.slave (run/halt/jump control, pc load/enable,
//         memory request/response, held instruction, busy/error status)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter word_t RESET_VECTOR = 16'h0000,
    parameter int    MEM_TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.slave    bus
);

    state_t state, state_next;
    logic   load_c, enable_c, accept, error_set;
    word_t  load_val_c;
    logic   wait_count, wait_expire;
    word_t  instr_q;
    logic   error_q;

    // Only plain waiting cycles count; anything that takes priority over
    // mem_ready also restarts the timeout.
    assign wait_count = (state == REQ) && !bus.halt_req && !bus.jump_valid && !bus.mem_ready;

    fetch_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!wait_count),
        .count_en (wait_count),
        .expire   (wait_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        load_val_c = RESET_VECTOR;
        enable_c   = 1'b0;
        accept     = 1'b0;
        error_set  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run && !bus.halt_req) begin
                    load_c     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.halt_req) begin
                    state_next = HALTED;
                end else if (bus.jump_valid) begin
                    load_c     = 1'b1;
                    load_val_c = bus.jump_addr;
                end else if (bus.mem_ready) begin
                    accept     = 1'b1;
                    enable_c   = 1'b1;
                    state_next = HOLD;
                end else if (wait_expire) begin
                    error_set  = 1'b1;
                    state_next = HALTED;
                end
            end
            HOLD: begin
                if (bus.halt_req) begin
                    state_next = HALTED;
                end else if (bus.jump_valid) begin
                    load_c     = 1'b1;
                    load_val_c = bus.jump_addr;
                    state_next = REQ;
                end else if (bus.instr_ack && !bus.stall) begin
                    state_next = bus.run ? REQ : IDLE;
                end
            end
            HALTED: begin
                if (!bus.halt_req && !bus.run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                instr_q <= bus.mem_rdata;
            end
            if (error_set) begin
                error_q <= 1'b1;
            end
        end
    end

    // Combinational strobes are masked by reset so that inputs such as run
    // cannot leak a pc_load out of IDLE while reset is held.
    assign bus.pc_load     = load_c && !reset;
    assign bus.pc_enable   = enable_c && !reset;
    assign bus.pc_load_val = load_val_c;
    assign bus.mem_req     = (state == REQ) && !reset;
    assign bus.mem_addr    = bus.pc_value;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr_out   = instr_q;
    assign bus.busy        = (state == REQ) || (state == HOLD);
    assign bus.error       = error_q;

endmodule
